rx_prbs_checker: RTL
====================

Name: rx_prbs_checker

Overview:
- Byte-wise PRBS-7 checker on the receive side of the optical link.
- Consumes the rx byte stream (d_out/d_out_valid from rx) in the clk_x8 domain and self-synchronises to the PRBS-7 pattern that tx emits when prbs_on=1.
- Reports lock status and saturating bit-error and byte counts, for link bring-up and BER soak tests on the board.

Parameters:
- LOCK_COUNT, 16, consecutive error-free bytes in VERIFY needed to declare lock (1..255).
- UNLOCK_COUNT, 8, consecutive errored bytes in LOCKED that drop lock (1..255).
- CNT_W, 32, width of bit_errors and byte_count.

Ports:
- clk_x8  in  1  system clock; same clock as rx.
- rst  in  1  synchronous, active-high reset.
- d_in  in  8  received byte; bit 0 is the first bit on the wire.
- d_in_valid  in  1  single-cycle strobe; d_in is valid only in that cycle.
- clear_counts  in  1  synchronous clear of bit_errors and byte_count; does not affect lock.
- locked  out  1  high in LOCKED state.
- err_flag  out  1  one-cycle pulse: the byte just checked in LOCKED had at least one bit error.
- bit_errors  out  CNT_W  saturating count of errored bits while LOCKED.
- byte_count  out  CNT_W  saturating count of bytes checked while LOCKED.

Behaviour:
- Sequence definition: b[n] = b[n-7] XOR b[n-6] (x^7+x^6+1). Byte k carries b[8k+i] in bit i.
- Predictor state: the 7 most recent bits. Next byte = 8 bits generated serially from that state, bit 0 first.
- Reset: state=HUNT, all counters=0, locked=0, err_flag=0, prediction register=0.
- All outputs are registered and update in the cycle after a d_in_valid strobe. Nothing changes on cycles without a strobe, except the clear_counts effect.
- HUNT:
  - On a strobe, load the predictor with d_in[7:1] (the last 7 bits received).
  - Set match_cnt=0 and go to VERIFY.
- VERIFY:
  - On a strobe, compare d_in with the predicted byte.
  - Match: match_cnt+1. If the result equals LOCK_COUNT, go to LOCKED with error_run=0.
  - Mismatch: reseed the predictor from d_in[7:1], match_cnt=0, stay in VERIFY.
  - Counters are not touched in VERIFY.
- LOCKED:
  - On a strobe, diff = d_in XOR predicted. byte_count+1.
  - bit_errors += popcount(diff), range 0..8; the sum saturates at all-ones.
  - err_flag=1 when diff≠0.
  - Predictor free-runs from its own state, never from received data, so a single bit flip counts as one error and does not propagate.
  - error_run: reset to 0 on any clean byte, +1 on an errored byte. On reaching UNLOCK_COUNT, go to HUNT: locked=0 next cycle, counters retained.
- Lock timing: locked asserts the cycle after the LOCK_COUNT-th matching strobe. err_flag is never asserted outside LOCKED.
- Saturation: neither counter wraps. Once at 2^CNT_W-1 it holds.
- clear_counts:
  - Zeroes both counters next cycle.
  - If it coincides with a LOCKED strobe, clear wins and the current byte is not counted. err_flag still reflects that byte.
- All-zero input: PRBS-7 never produces an all-zero state. A seed of d_in[7:1]=0 is treated as a mismatch in VERIFY, which reseeds and prevents false lock on a dead or idle link.
- rst asserted mid-operation returns to reset values on the next edge, regardless of strobe.

Test Plan:
- Reset, then feed 40 strobed bytes of the correct PRBS-7 (seed 7'h7F), spaced 10 clocks apart -> locked rises after the 17th strobe (1 seed + 16 matches); byte_count equals bytes fed after lock; bit_errors=0; err_flag never pulses.
- Once locked, flip bit 3 of one byte, then flip 0xFF on another byte -> bit_errors increments by 1 then by 8; err_flag pulses twice; the following clean bytes are counted as clean, with no error propagation.
- Once locked, replace 8 consecutive bytes with 0x00 -> locked falls after the 8th; after 17 further correct bytes it reasserts; counters are unchanged while unlocked.
- Feed constant 0x00 for 100 strobes from reset -> locked stays 0 and the checker stays in VERIFY.
- Preload near saturation (CNT_W=4): inject errors until bit_errors=15 -> it holds at 15. Assert clear_counts on the same cycle as an errored strobe -> both counters are 0 next cycle and err_flag=1.
- Assert rst for one cycle while locked -> all outputs 0 next cycle; relock takes the full 17 strobes.

Source files
------------

// File: rtl/rx_prbs_checker.sv
// Byte-wise PRBS-7 (x^7+x^6+1) receive checker: self-synchronises to the rx
// byte stream, tracks lock, and keeps saturating bit-error and byte counts.
module rx_prbs_checker #(
  parameter int unsigned LOCK_COUNT   = 16,
  parameter int unsigned UNLOCK_COUNT = 8,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk_x8,
  input  logic             rst,
  input  logic [7:0]       d_in,
  input  logic             d_in_valid,
  input  logic             clear_counts,
  output logic             locked,
  output logic             err_flag,
  output logic [CNT_W-1:0] bit_errors,
  output logic [CNT_W-1:0] byte_count
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Wide enough to hold count + 8 without overflow, so saturation is a compare.
  localparam int unsigned SUM_W = ((CNT_W > 4) ? CNT_W : 4) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  state_t state, state_nxt;
  logic [6:0] seed, seed_nxt;
  logic [7:0] match_cnt, match_cnt_nxt, match_inc;
  logic [7:0] error_run, error_run_nxt, run_inc;
  logic [7:0] pred, diff;
  logic [3:0] diff_ones;
  logic [SUM_W-1:0] be_sum;
  logic             err_flag_nxt;
  logic [CNT_W-1:0] bit_errors_nxt, byte_count_nxt;

  // Predictor: seed[0] is the oldest of the 7 most recent bits, seed[6] the newest.
  always_comb begin
    logic [6:0] s;
    s    = seed;
    pred = '0;
    for (int i = 0; i < 8; i++) begin
      pred[i] = s[0] ^ s[1];
      s       = {pred[i], s[6:1]};
    end
  end

  always_comb begin
    diff      = d_in ^ pred;
    diff_ones = '0;
    for (int i = 0; i < 8; i++) diff_ones = diff_ones + 4'(diff[i]);
    match_inc = match_cnt + 8'd1;
    run_inc   = error_run + 8'd1;
    be_sum    = SUM_W'(bit_errors) + SUM_W'(diff_ones);
  end

  // State register.
  always_ff @(posedge clk_x8) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state      <= HUNT;
      seed       <= '0;
      match_cnt  <= '0;
      error_run  <= '0;
      err_flag   <= 1'b0;
      bit_errors <= '0;
      byte_count <= '0;
    end else begin
      state      <= state_nxt;
      seed       <= seed_nxt;
      match_cnt  <= match_cnt_nxt;
      error_run  <= error_run_nxt;
      err_flag   <= err_flag_nxt;
      bit_errors <= bit_errors_nxt;
      byte_count <= byte_count_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path infers a latch.
    state_nxt     = state;
    seed_nxt      = seed;
    match_cnt_nxt = match_cnt;
    error_run_nxt = error_run;
    if (d_in_valid) begin
      unique case (state)
        HUNT: begin
          seed_nxt      = d_in[7:1];
          match_cnt_nxt = '0;
          state_nxt     = VERIFY;
        end
        VERIFY: begin
          // An all-zero seed can never be PRBS-7, so it never counts as a match.
          if (diff == '0 && seed != '0) begin
            seed_nxt      = pred[7:1];
            match_cnt_nxt = match_inc;
            if (match_inc == 8'(LOCK_COUNT)) begin
              state_nxt     = LOCKED;
              error_run_nxt = '0;
            end
          end else begin
            seed_nxt      = d_in[7:1];
            match_cnt_nxt = '0;
          end
        end
        LOCKED: begin
          // Free-running: received errors never leak into the predictor.
          seed_nxt = pred[7:1];
          if (diff == '0) begin
            error_run_nxt = '0;
          end else begin
            error_run_nxt = run_inc;
            if (run_inc == 8'(UNLOCK_COUNT)) state_nxt = HUNT;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    locked         = (state == LOCKED);
    err_flag_nxt   = 1'b0;
    bit_errors_nxt = bit_errors;
    byte_count_nxt = byte_count;
    if (d_in_valid && state == LOCKED) begin
      err_flag_nxt   = (diff != '0);
      bit_errors_nxt = (be_sum > CNT_MAX) ? {CNT_W{1'b1}} : CNT_W'(be_sum);
      byte_count_nxt = (&byte_count) ? byte_count : byte_count + 1'b1;
    end
    if (clear_counts) begin
      bit_errors_nxt = '0;
      byte_count_nxt = '0;
    end
  end

endmodule
